// File: rtl/instruction_prefetcher_pkg.sv
// Shared widths and helpers for the instruction prefetcher.
package instruction_prefetcher_pkg;

    localparam int IMEM_AW = 32;
    localparam int IMEM_DW = 32;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instruction_prefetcher_sync_fifo.sv
// Small synchronous FIFO with a flush that wins over push/pop.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo
    import instruction_prefetcher_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = cnt_width(DEPTH),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= wdata;
    end

    // Callers size their credits so a push never meets a full FIFO.
    always @(posedge clk) begin
        if (rst_n && !flush) assert (!(push && full && !pop));
    end

endmodule

// File: rtl/instruction_prefetcher.sv
// Sequential instruction prefetcher: credit-limited fetch into a small
// buffer, with redirect that discards everything still in flight.
module instruction_prefetcher
    import instruction_prefetcher_pkg::*;
#(
    parameter int                  ADDR_WIDTH = IMEM_AW,
    parameter int                  DATA_WIDTH = IMEM_DW,
    parameter int                  DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = cnt_width(DEPTH);
    localparam int SW = CW + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, pcq_rdata;
    logic [CW-1:0]         outst_q, outst_d, drop_q, drop_d;
    logic [CW-1:0]         ib_cnt, pcq_cnt;
    logic [SW-1:0]         credit_used;
    logic                  accept, rsp_live, rsp_drop, ib_empty, pcq_empty;

    // Buffered plus in-flight words may never exceed the buffer size.
    assign credit_used = SW'(ib_cnt) + SW'(outst_q);
    assign mem_req     = !redirect && (credit_used < SW'(DEPTH));
    assign mem_addr    = fetch_pc_q;
    assign accept      = mem_req && mem_ready;
    assign rsp_live    = mem_rvalid && !redirect && (drop_q == '0);
    assign rsp_drop    = mem_rvalid && !redirect && (drop_q != '0);
    assign instr_valid = !ib_empty;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (accept) fetch_pc_d = fetch_pc_q + 1'b1;
        if (accept && !mem_rvalid)      outst_d = outst_q + 1'b1;
        else if (!accept && mem_rvalid) outst_d = outst_q - 1'b1;
        if (rsp_drop) drop_d = drop_q - 1'b1;
        // A response landing on the redirect cycle is already accounted for.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            drop_d     = outst_q - CW'(mem_rvalid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(.WIDTH(ADDR_WIDTH + DATA_WIDTH), .DEPTH(DEPTH)) u_ibuf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (rsp_live),
        .wdata ({pcq_rdata, mem_rdata}),
        .pop   (instr_valid && instr_ready),
        .rdata ({instr_pc, instr}),
        .empty (ib_empty),
        .count (ib_cnt)
    );

    sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_pcq (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (accept),
        .wdata (fetch_pc_q),
        .pop   (rsp_live),
        .rdata (pcq_rdata),
        .empty (pcq_empty),
        .count (pcq_cnt)
    );

    // The pc queue tracks exactly the live (non-dropped) requests.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(rsp_live && pcq_empty));
            assert (pcq_cnt == outst_q - drop_q);
        end
    end

endmodule

// File: tb/tb_instruction_prefetcher.sv
// Scoreboard bench: expected pcs are queued when a fetch stream is started
// (reset/redirect) and compared as the consumer pops words.
module tb_instruction_prefetcher;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] RPC = 8'h10;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          instr_valid, instr_ready = 1'b0;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          mem_req, mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    instruction_prefetcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct { logic [AW-1:0] a; int rdy; } mreq_t;

    int            errs = 0, checks = 0, cyc = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_next;
    mreq_t         mq[$];
    int            p_ready = 100, p_rvalid = 100, p_ireq = 100, lat_min = 1, lat_max = 1;
    bit            freeze = 0, popped = 0;
    int            n_acc = 0, n_pop = 0, first_valid = -1;
    logic [AW-1:0] last_pop_pc;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic seed(input logic [AW-1:0] pc);
        exp_q.delete();
        exp_next = pc;
        repeat (2 * DEPTH) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 1'b1;
        end
    endtask

    task automatic drive_sample(input bit rd, input logic [AW-1:0] rpc);
        logic [AW-1:0] e;
        redirect    = rd;
        redirect_pc = rpc;
        instr_ready = ($urandom_range(99) < p_ireq);
        mem_ready   = ($urandom_range(99) < p_ready);
        if (mq.size() > 0 && !freeze && mq[0].rdy <= cyc && $urandom_range(99) < p_rvalid) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(mq[0].a);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        @(negedge clk);
        popped = 0;
        if (mem_rvalid) void'(mq.pop_front());
        if (mem_req && mem_ready) begin
            mq.push_back('{mem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            n_acc++;
        end
        if (first_valid < 0 && instr_valid) first_valid = cyc;
        if (instr_valid && instr_ready && !redirect) begin
            popped = 1;
            last_pop_pc = instr_pc;
            n_pop++;
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e);
            chk("instr", instr, mem_word(e));
            exp_q.push_back(exp_next);
            exp_next = exp_next + 1'b1;
        end
        if (redirect) seed(redirect_pc);
    endtask

    task automatic step(input bit rd = 0, input logic [AW-1:0] rpc = '0);
        @(posedge clk);
        #1;
        cyc++;
        drive_sample(rd, rpc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        redirect = 1'b0;
        mem_rvalid = 1'b0;
        mq.delete();
        #1;
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_mem_addr", mem_addr, RPC);
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        n_acc = 0;
        n_pop = 0;
        first_valid = -1;
        seed(RPC);
        drive_sample(0, '0);
        chk("post_rst_mem_req", mem_req, 1);
        chk("post_rst_mem_addr", mem_addr, RPC);
    endtask

    task automatic wait_pop(input string tag);
        int n = 0;
        while (!popped && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_pop_timeout"}, popped, 1);
    endtask

    initial begin
        // Zero-wait memory: first word 2 cycles after reset, then one per cycle.
        do_reset();
        release_reset();
        repeat (13) step();
        chk("first_valid_cycle", first_valid, 2);
        chk("stream_pops", n_pop, 12);

        // Stalled consumer: exactly DEPTH requests, then none until a pop.
        do_reset();
        p_ireq = 0;
        release_reset();
        repeat (20) step();
        chk("stall_accepts", n_acc, DEPTH);
        chk("stall_mem_req", mem_req, 0);
        p_ireq = 100;
        step();
        chk("stall_one_pop", n_pop, 1);
        p_ireq = 0;
        step();
        chk("after_pop_mem_req", mem_req, 1);
        chk("after_pop_accepts", n_acc, DEPTH + 1);

        // Redirect with three requests outstanding.
        do_reset();
        freeze = 1;
        release_reset();
        repeat (2) step();
        chk("redir_outstanding", mq.size(), 3);
        step(1, 8'h40);
        chk("redir_no_req", mem_req, 0);
        freeze = 0;
        p_ireq = 100;
        wait_pop("redir");
        chk("redir_first_pc", last_pop_pc, 8'h40);

        // Address wrap at the top of the space, no stall across it.
        do_reset();
        release_reset();
        repeat (10) step();
        step(1, 8'hFE);
        n_pop = 0;
        repeat (12) step();
        chk("wrap_pops", n_pop, 10);

        // Reset with buffered and in-flight words.
        do_reset();
        p_ireq = 0;
        release_reset();
        step();
        freeze = 1;
        repeat (2) step();
        chk("pre_reset_valid", instr_valid, 1);
        do_reset();
        freeze = 0;
        p_ireq = 100;
        release_reset();
        wait_pop("restart");
        chk("restart_pc", last_pop_pc, RPC);

        // Random memory timing, consumer stalls and redirects.
        do_reset();
        p_ready = 70; p_rvalid = 80; p_ireq = 70; lat_min = 1; lat_max = 4;
        release_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 2) step(1, AW'($urandom));
            else step();
        end
        p_ireq = 100;
        repeat (30) step();
        chk("random_liveness", n_pop > 300, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
